// File: rtl/brick_hit_sched.sv
// brick_hit_sched: brick-wall collision scheduler.
// A check scans the 4 wall rows one per cycle and removes at most one brick:
// the highest overlapped brick in the lowest matching row.
// Optional feature: define BRICK_SCORE_EN to enable the saturating score counter;
// when it is undefined the score port is tied to zero.
//
// state | meaning
// IDLE  | waiting for start; hit/hit_row/hit_brk hold the last result
// SCAN  | evaluating row row_idx against the latched ball_rows/ball_mask
// CLEAR | removing brick {hit_row, hit_brk} from the wall
// DONE  | check finished; done pulses on the following cycle

module brick_hit_sched (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  ball_rows,
    input  logic [7:0]  ball_mask,
    input  logic        wall_load,
    output logic        busy,
    output logic        done,
    output logic        hit,
    output logic [1:0]  hit_row,
    output logic [2:0]  hit_brk,
    output logic [31:0] wall,
    output logic        wall_clear,
    output logic [7:0]  score
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        CLEAR = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  row_idx;
    logic [3:0]  rows_q;
    logic [7:0]  mask_q;
    logic [7:0]  row_bits;
    logic        row_match;
    logic [2:0]  match_brk;

    // Current row overlap and the highest overlapped brick in it
    always_comb begin
        row_bits  = wall[{row_idx, 3'b000} +: 8] & mask_q;
        row_match = rows_q[row_idx] && (row_bits != 8'h00);
        match_brk = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (row_bits[i]) begin
                match_brk = i[2:0];
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and busy decode; wall_load aborts any check
    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        if (wall_load) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE:    if (start) state_nxt = SCAN;
                SCAN: begin
                    if (row_match) begin
                        state_nxt = CLEAR;
                    end else if (row_idx == 2'd3) begin
                        state_nxt = DONE;
                    end
                end
                CLEAR:   state_nxt = DONE;
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Datapath: input latch, row walk, hit capture, brick removal, done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            row_idx    <= 2'd0;
            rows_q     <= 4'd0;
            mask_q     <= 8'd0;
            hit        <= 1'b0;
            hit_row    <= 2'd0;
            hit_brk    <= 3'd0;
            wall       <= 32'hFFFF_FFFF;
            wall_clear <= 1'b0;
            done       <= 1'b0;
        end else begin
            done       <= (state == DONE) && !wall_load;
            wall_clear <= (wall == 32'd0);
            if (wall_load) begin
                wall <= 32'hFFFF_FFFF;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start) begin
                            rows_q  <= ball_rows;
                            mask_q  <= ball_mask;
                            row_idx <= 2'd0;
                            hit     <= 1'b0;
                            hit_row <= 2'd0;
                            hit_brk <= 3'd0;
                        end
                    end
                    SCAN: begin
                        if (row_match) begin
                            hit     <= 1'b1;
                            hit_row <= row_idx;
                            hit_brk <= match_brk;
                        end else begin
                            row_idx <= row_idx + 2'd1;
                        end
                    end
                    CLEAR:   wall[{hit_row, hit_brk}] <= 1'b0;
                    default: ;
                endcase
            end
        end
    end

`ifdef BRICK_SCORE_EN
    // Saturating count of removed bricks; an aborted CLEAR removes nothing
    always_ff @(posedge clk) begin
        if (rst) begin
            score <= 8'd0;
        end else if ((state == CLEAR) && !wall_load && (score != 8'hFF)) begin
            score <= score + 8'd1;
        end
    end
`else
    assign score = 8'd0;
`endif

endmodule

// File: doc/brick_hit_sched.md
BRICK_HIT_SCHED -- requirements
Module: brick_hit_sched

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge; single clock domain.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 start  input  1  request one collision check; accepted only in IDLE.
REQ-004 ball_rows  input  4  rows overlapped by ball; bit r = row r.
REQ-005 ball_mask  input  8  brick columns overlapped by ball; bit i = brick i.
REQ-006 wall_load  input  1  refill wall to all bricks present; accepted in any state.
REQ-007 busy  output  1  high in SCAN, CLEAR, DONE.
REQ-008 done  output  1  one-cycle pulse ending each accepted check.
REQ-009 hit  output  1  last completed check removed a brick.
REQ-010 hit_row  output  2  row of removed brick.
REQ-011 hit_brk  output  3  brick index within row.
REQ-012 wall  output  32  brick state; bits [8r+7:8r] = row r; 1 = brick present.
REQ-013 wall_clear  output  1  registered; high when wall == 0.
REQ-014 score  output  8  bricks removed since reset.

Function
REQ-015 FSM states SHALL be IDLE, SCAN, CLEAR, DONE.
REQ-016 IDLE + start: SHALL latch ball_rows/ball_mask, set row index 0, clear hit/hit_row/hit_brk, enter SCAN.
REQ-017 Each SCAN cycle SHALL evaluate exactly one row r = current index, using latched inputs only.
REQ-018 Row r matches when ball_rows[r]=1 and (wall row r AND ball_mask) != 0.
REQ-019 Match: record r in hit_row, HIGHEST set bit index of the AND in hit_brk, set hit, enter CLEAR.
REQ-020 No match, r<3: increment index, stay SCAN; no match, r=3: enter DONE with hit=0.
REQ-021 CLEAR SHALL zero wall bit 8*hit_row+hit_brk, then enter DONE; at most one brick removed per check.
REQ-022 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-023 Latency, start-accept edge to done high: r+3 cycles on hit in row r; 5 cycles on miss.
REQ-024 start while busy SHALL be ignored (not queued).
REQ-025 wall_load SHALL set wall to 32'hFFFF_FFFF and force IDLE next cycle; an in-flight check aborts with no done pulse and no brick removal.
REQ-026 wall_load and start in same cycle: wall_load wins; start dropped.
REQ-027 wall_clear SHALL reflect wall value one cycle after any wall update.
REQ-028 hit, hit_row, hit_brk SHALL hold from DONE until next accepted start or rst.
REQ-029 Check on empty wall SHALL complete as a miss with normal done pulse.

Reset
REQ-030 rst SHALL override all other inputs, including wall_load and start.
REQ-031 rst values: state IDLE, wall 32'hFFFF_FFFF, busy 0, done 0, hit 0, hit_row 0, hit_brk 0, wall_clear 0, score 0.
REQ-032 rst mid-check SHALL abort without done pulse or brick removal.

Configuration
REQ-033 Macro BRICK_SCORE_EN defined: score SHALL increment by 1 in each CLEAR cycle, saturating at 255; only rst clears it (wall_load does not).
REQ-034 BRICK_SCORE_EN undefined: score port SHALL remain, tied to 8'd0; no score counter logic.

Verification
REQ-035 After rst, start with ball_rows=4'b0001, ball_mask=8'h81 -> done 3 cycles after accept, hit=1, hit_row=0, hit_brk=7, wall=32'hFFFF_FF7F, score=1 (with macro).
REQ-036 ball_rows=4'b1000, ball_mask=8'h04 -> hit_row=3, hit_brk=2, done 6 cycles after accept, wall bit 26 cleared.
REQ-037 ball_rows=4'b0000 -> done 5 cycles after accept, hit=0, wall unchanged; start pulsed during SCAN ignored (single done).
REQ-038 wall_load asserted in SCAN cycle 2 of a row-3 check -> no done, wall=32'hFFFF_FFFF, busy=0 next cycle.
REQ-039 Clear all 32 bricks via 32 checks -> wall_clear=1 one cycle after last CLEAR, score=32; further check gives hit=0.
REQ-040 rst asserted same cycle as start and wall_load -> all outputs at reset values, busy stays 0.
